snake_game_sequencer: RTL and testbench



---
 rtl/snake_pkg.sv | 36 +++
 rtl/snake_step_timer.sv | 27 ++
 rtl/snake_game_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_snake_game_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - state encodings, period width and timing defaults for the snake game sequencer
package snake_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_RUN       = 3'd2,
    ST_PAUSE     = 3'd3,
    ST_DYING     = 3'd4,
    ST_OVER      = 3'd5
  } game_state_t;

  localparam int PERIOD_W = 23;

  localparam int DEF_BASE_PERIOD      = 5_000_000;
  localparam int DEF_MIN_PERIOD       = 1_666_666;
  localparam int DEF_PERIOD_DEC       = 333_333;
  localparam int DEF_APPLES_PER_LEVEL = 5;
  localparam int DEF_MAX_LEVEL        = 15;
  localparam int DEF_FRAMES_PER_COUNT = 60;
  localparam int DEF_COUNT_START      = 3;
  localparam int DEF_FLASH_FRAMES     = 8;
  localparam int DEF_DEATH_FRAMES     = 96;

  // max(period - dec, min_period), compared first so the subtraction never wraps
  function automatic logic [PERIOD_W-1:0] faster_period(
    input logic [PERIOD_W-1:0] period,
    input logic [PERIOD_W-1:0] min_period,
    input logic [PERIOD_W-1:0] dec
  );
    if (period < min_period || (period - min_period) < dec)
      return min_period;
    return period - dec;
  endfunction

endpackage

// File: rtl/snake_step_timer.sv
// rtl/snake_step_timer.sv - loadable down-counter that flags expiry while enabled
module snake_step_timer
  import snake_pkg::*;
(
  input  logic                clk_pix,
  input  logic                reset,
  input  logic                load,
  input  logic [PERIOD_W-1:0] load_val,
  input  logic                en,
  output logic                expire
);

  logic [PERIOD_W-1:0] cnt;

  // parks at zero rather than wrapping when an expiry is not followed by a reload
  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (en && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign expire = en && (cnt == '0);

endmodule

// File: rtl/snake_game_sequencer.sv
// rtl/snake_game_sequencer.sv - round flow, countdown, variable-rate step timer and death animation
module snake_game_sequencer
  import snake_pkg::*;
#(
  parameter int BASE_PERIOD      = DEF_BASE_PERIOD,
  parameter int MIN_PERIOD       = DEF_MIN_PERIOD,
  parameter int PERIOD_DEC       = DEF_PERIOD_DEC,
  parameter int APPLES_PER_LEVEL = DEF_APPLES_PER_LEVEL,
  parameter int MAX_LEVEL        = DEF_MAX_LEVEL,
  parameter int FRAMES_PER_COUNT = DEF_FRAMES_PER_COUNT,
  parameter int COUNT_START      = DEF_COUNT_START,
  parameter int FLASH_FRAMES     = DEF_FLASH_FRAMES,
  parameter int DEATH_FRAMES     = DEF_DEATH_FRAMES
) (
  input  logic       clk_pix,
  input  logic       reset,
  input  logic       start_n,
  input  logic       pause_n,
  input  logic       frame_start,
  input  logic       eat_evt,
  input  logic       self_hit,
  input  logic       wall_hit,
  output logic       tick_run,
  output logic       soft_reset,
  output logic [2:0] state,
  output logic [1:0] countdown,
  output logic [3:0] level,
  output logic       flash,
  output logic       game_over
);

  localparam int FRAME_MAX = (DEATH_FRAMES > FRAMES_PER_COUNT) ? DEATH_FRAMES : FRAMES_PER_COUNT;
  localparam int FW  = $clog2(FRAME_MAX + 1);
  localparam int FLW = $clog2(FLASH_FRAMES + 1);
  localparam int AW  = $clog2(APPLES_PER_LEVEL + 1);

  localparam logic [PERIOD_W-1:0] BASE_P     = PERIOD_W'(BASE_PERIOD);
  localparam logic [PERIOD_W-1:0] MIN_P      = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] DEC_P      = PERIOD_W'(PERIOD_DEC);
  localparam logic [FW-1:0]       COUNT_LAST = FW'(FRAMES_PER_COUNT - 1);
  localparam logic [FW-1:0]       DEATH_LAST = FW'(DEATH_FRAMES - 1);
  localparam logic [FLW-1:0]      FLASH_LAST = FLW'(FLASH_FRAMES - 1);
  localparam logic [AW-1:0]       APPLE_LAST = AW'(APPLES_PER_LEVEL - 1);
  localparam logic [3:0]          LEVEL_MAX  = 4'(MAX_LEVEL);
  localparam logic [1:0]          COUNT_INIT = 2'(COUNT_START);

  game_state_t         state_q, state_d;
  logic                start_q, pause_q;
  logic [1:0]          countdown_q, countdown_d;
  logic [3:0]          level_q, level_d;
  logic                flash_q, flash_d;
  logic                game_over_q;
  logic                tick_q, tick_d;
  logic                soft_q, soft_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [AW-1:0]       apple_q, apple_d;
  logic [FW-1:0]       frame_q, frame_d;
  logic [FLW-1:0]      flash_cnt_q, flash_cnt_d;
  logic                load, expire;
  logic                start_press, pause_press;

  assign start_press = start_q && !start_n;
  assign pause_press = pause_q && !pause_n;

  snake_step_timer u_step_timer (
    .clk_pix  (clk_pix),
    .reset    (reset),
    .load     (load),
    .load_val (period_q),
    .en       (state_q == ST_RUN),
    .expire   (expire)
  );

  always_comb begin
    state_d     = state_q;
    countdown_d = countdown_q;
    level_d     = level_q;
    flash_d     = flash_q;
    period_d    = period_q;
    apple_d     = apple_q;
    frame_d     = frame_q;
    flash_cnt_d = flash_cnt_q;
    tick_d      = 1'b0;
    soft_d      = 1'b0;
    load        = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_press) begin
          state_d     = ST_COUNTDOWN;
          soft_d      = 1'b1;
          countdown_d = COUNT_INIT;
          level_d     = '0;
          apple_d     = '0;
          period_d    = BASE_P;
          frame_d     = '0;
        end
      end
      ST_COUNTDOWN: begin
        if (frame_start) begin
          if (frame_q == COUNT_LAST) begin
            frame_d     = '0;
            countdown_d = countdown_q - 2'd1;
            if (countdown_q == 2'd1) begin
              state_d = ST_RUN;
              load    = 1'b1;
            end
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (eat_evt) begin
          if (apple_q == APPLE_LAST) begin
            apple_d  = '0;
            period_d = faster_period(period_q, MIN_P, DEC_P);
            if (level_q != LEVEL_MAX)
              level_d = level_q + 4'd1;
          end else begin
            apple_d = apple_q + 1'b1;
          end
        end
        // a collision beats a coincident expiry; pause still lets that expiry tick
        if (self_hit || wall_hit) begin
          state_d     = ST_DYING;
          flash_d     = 1'b1;
          frame_d     = '0;
          flash_cnt_d = '0;
        end else begin
          if (expire) begin
            tick_d = 1'b1;
            load   = 1'b1;
          end
          if (pause_press)
            state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (pause_press)
          state_d = ST_RUN;
      end
      ST_DYING: begin
        if (frame_start) begin
          if (frame_q == DEATH_LAST) begin
            state_d = ST_OVER;
            flash_d = 1'b0;
          end else begin
            frame_d = frame_q + 1'b1;
            if (flash_cnt_q == FLASH_LAST) begin
              flash_cnt_d = '0;
              flash_d     = !flash_q;
            end else begin
              flash_cnt_d = flash_cnt_q + 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // button history resets to 0 so a button held through reset is not a press
  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      pause_q     <= 1'b0;
      countdown_q <= '0;
      level_q     <= '0;
      flash_q     <= 1'b0;
      game_over_q <= 1'b0;
      tick_q      <= 1'b0;
      soft_q      <= 1'b0;
      period_q    <= BASE_P;
      apple_q     <= '0;
      frame_q     <= '0;
      flash_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_n;
      pause_q     <= pause_n;
      countdown_q <= countdown_d;
      level_q     <= level_d;
      flash_q     <= flash_d;
      game_over_q <= (state_d == ST_OVER);
      tick_q      <= tick_d;
      soft_q      <= soft_d;
      period_q    <= period_d;
      apple_q     <= apple_d;
      frame_q     <= frame_d;
      flash_cnt_q <= flash_cnt_d;
    end
  end

  assign tick_run   = tick_q;
  assign soft_reset = soft_q;
  assign state      = state_q;
  assign countdown  = countdown_q;
  assign level      = level_q;
  assign flash      = flash_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_snake_game_sequencer.sv
// tb/tb_snake_game_sequencer.sv - directed self-checking bench for snake_game_sequencer
module tb_snake_game_sequencer;

  logic       clk_pix = 1'b0;
  logic       reset;
  logic       start_n, pause_n, frame_start, eat_evt, self_hit, wall_hit;
  logic       tick_run, soft_reset, flash, game_over;
  logic [2:0] state;
  logic [1:0] countdown;
  logic [3:0] level;

  int errors = 0;
  int checks = 0;
  int n;
  int ticks_seen;

  always #5 clk_pix = ~clk_pix;

  snake_game_sequencer #(
    .BASE_PERIOD      (20),
    .MIN_PERIOD       (8),
    .PERIOD_DEC       (5),
    .APPLES_PER_LEVEL (2),
    .MAX_LEVEL        (3),
    .FRAMES_PER_COUNT (3),
    .COUNT_START      (3),
    .FLASH_FRAMES     (2),
    .DEATH_FRAMES     (6)
  ) dut (
    .clk_pix     (clk_pix),
    .reset       (reset),
    .start_n     (start_n),
    .pause_n     (pause_n),
    .frame_start (frame_start),
    .eat_evt     (eat_evt),
    .self_hit    (self_hit),
    .wall_hit    (wall_hit),
    .tick_run    (tick_run),
    .soft_reset  (soft_reset),
    .state       (state),
    .countdown   (countdown),
    .level       (level),
    .flash       (flash),
    .game_over   (game_over)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
  endtask

  task automatic press_start();
    start_n = 1'b0;
    step();
    start_n = 1'b1;
  endtask

  task automatic press_pause();
    pause_n = 1'b0;
    step();
    pause_n = 1'b1;
  endtask

  // steps until tick_run is seen; returns the number of steps taken
  task automatic wait_tick(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!tick_run && cnt < 200);
  endtask

  // eight frames with idle gaps, then the ninth frame which enters RUN
  task automatic run_countdown();
    for (int i = 0; i < 8; i++) frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start_n = 1'b1; pause_n = 1'b1; frame_start = 1'b0;
    eat_evt = 1'b0; self_hit = 1'b0; wall_hit = 1'b0;
    repeat (3) step();
    check_eq("rst_state", state, 0);
    check_eq("rst_tick", tick_run, 0);
    check_eq("rst_soft", soft_reset, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_over", game_over, 0);
    reset = 1'b0;
    eat_evt = 1'b1;
    repeat (2) step();
    eat_evt = 1'b0;
    check_eq("idle_level_eat_ignored", level, 0);

    // start and countdown
    press_start();
    check_eq("start_state", state, 1);
    check_eq("start_soft", soft_reset, 1);
    check_eq("start_cd", countdown, 3);
    step();
    check_eq("soft_one_cycle", soft_reset, 0);
    for (int i = 1; i <= 8; i++) begin
      frame();
      check_eq($sformatf("cd_after_%0d", i), countdown, 3 - i / 3);
    end
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check_eq("run_state", state, 2);
    check_eq("run_cd", countdown, 0);
    wait_tick(n);
    check_eq("first_tick", n, 21);
    wait_tick(n);
    check_eq("tick_gap_l0", n, 21);

    // level 1: two eats, new period on next reload
    eat_evt = 1'b1; step(); step(); eat_evt = 1'b0;
    check_eq("level1", level, 1);
    wait_tick(n);
    check_eq("tick_gap_old_period", 2 + n, 21);
    wait_tick(n);
    check_eq("tick_gap_l1", n, 16);

    // level 2: second eat coincides with expiry, reload uses old period
    eat_evt = 1'b1; step(); eat_evt = 1'b0;
    repeat (14) step();
    eat_evt = 1'b1; step(); eat_evt = 1'b0;
    check_eq("tick_with_eat", tick_run, 1);
    check_eq("level2", level, 2);
    wait_tick(n);
    check_eq("tick_gap_eat_same", n, 16);
    wait_tick(n);
    check_eq("tick_gap_l2", n, 11);

    // level 3 then saturation; period clamps at 8
    eat_evt = 1'b1; step(); step();
    check_eq("level3", level, 3);
    step(); step(); eat_evt = 1'b0;
    check_eq("level_sat", level, 3);
    wait_tick(n);
    check_eq("tick_gap_l2_reload", 4 + n, 11);
    wait_tick(n);
    check_eq("tick_gap_floor", n, 9);
    wait_tick(n);
    check_eq("tick_gap_floor2", n, 9);

    // pause: freeze, ignore start and hits, resume with remaining count
    repeat (3) step();
    press_pause();
    check_eq("pause_state", state, 3);
    ticks_seen = 0;
    self_hit = 1'b1;
    repeat (4) begin step(); ticks_seen += int'(tick_run); end
    press_start();
    ticks_seen += int'(tick_run);
    repeat (5) begin step(); ticks_seen += int'(tick_run); end
    self_hit = 1'b0;
    check_eq("pause_hold_state", state, 3);
    check_eq("pause_no_tick", ticks_seen, 0);
    press_pause();
    check_eq("resume_state", state, 2);
    wait_tick(n);
    check_eq("resume_tick", n, 5);

    // hit on the expiry cycle
    repeat (8) step();
    self_hit = 1'b1; step(); self_hit = 1'b0;
    check_eq("hit_no_tick", tick_run, 0);
    check_eq("dying_state", state, 4);
    check_eq("dying_flash0", flash, 1);
    for (int i = 1; i <= 5; i++) begin
      frame();
      check_eq($sformatf("flash_after_%0d", i), flash, ((i / 2) % 2 == 0) ? 1 : 0);
      check_eq($sformatf("dying_state_%0d", i), state, 4);
    end
    frame();
    check_eq("over_state", state, 5);
    check_eq("over_flash", flash, 0);
    check_eq("over_flag", game_over, 1);
    eat_evt = 1'b1; step(); eat_evt = 1'b0;
    check_eq("over_eat_ignored", level, 3);

    // restart from OVER
    press_start();
    check_eq("restart_state", state, 1);
    check_eq("restart_soft", soft_reset, 1);
    check_eq("restart_level", level, 0);
    check_eq("restart_over", game_over, 0);

    // mid-run asynchronous reset at level 3
    run_countdown();
    check_eq("run2_state", state, 2);
    eat_evt = 1'b1; repeat (6) step(); eat_evt = 1'b0;
    check_eq("run2_level3", level, 3);
    #2 reset = 1'b1;
    #1;
    check_eq("async_state", state, 0);
    check_eq("async_level", level, 0);
    check_eq("async_tick", tick_run, 0);
    check_eq("async_flash", flash, 0);
    step();
    reset = 1'b0;
    repeat (2) step();
    press_start();
    check_eq("clean_start_state", state, 1);
    check_eq("clean_start_soft", soft_reset, 1);
    run_countdown();
    wait_tick(n);
    check_eq("clean_first_tick", n, 21);
    check_eq("clean_level", level, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
